// File: rtl/ws2811_serial_decoder.sv
// ws2811_serial_decoder: decodes a WS2811 NRZ pulse stream into 24-bit GRB words and detects latch gaps.
// Define WS2811_DECODER_FORWARD_EN for pixel mode: decode word 0 only, forward the rest on o_serial_out.
module ws2811_serial_decoder #(
  parameter int BIT_THRESHOLD = 30,
  parameter int MIN_HIGH      = 5,
  parameter int RESET_CYCLES  = 2500
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_serial_in,
  output logic [23:0] o_word,
  output logic        o_word_valid,
  output logic [7:0]  o_word_count,
  output logic        o_frame_done,
  output logic        o_error,
`ifdef WS2811_DECODER_FORWARD_EN
  output logic        o_serial_out,
`endif
  output logic [1:0]  o_db_estado
);
  // state | meaning
  // IDLE  | decoder disabled, partial word discarded
  // LOW   | line low, timing the gap
  // HIGH  | line high, timing the pulse
  // STUCK | line held high too long, waiting for it to drop
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOW   = 2'b01,
    S_HIGH  = 2'b10,
    S_STUCK = 2'b11
  } state_t;

  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] C_ONE       = CW'(1);
  localparam logic [CW-1:0] C_MIN_HIGH  = CW'(MIN_HIGH);
  localparam logic [CW-1:0] C_THRESHOLD = CW'(BIT_THRESHOLD);
  localparam logic [CW-1:0] C_LAST      = CW'(RESET_CYCLES - 1);

  logic          r_sync1, r_sync2;
  logic          w_line;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_high_cnt, w_high_nxt;
  logic [CW-1:0] r_low_cnt, w_low_nxt;
  logic [4:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]    r_word_cnt, w_word_cnt_nxt;
  logic [22:0]   r_shift, w_shift_nxt;
  logic [23:0]   r_word, w_word_nxt;
  logic [7:0]    r_word_count, w_word_count_nxt;
  logic          r_word_valid, w_valid_nxt;
  logic          r_frame_done, w_done_nxt;
  logic          r_error, w_error_nxt;
  logic          w_bit;
  logic          w_decode_en;

  assign w_line = r_sync2;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + C_ONE;
  endfunction

  always_comb begin
    w_state_nxt      = r_state;
    w_high_nxt       = r_high_cnt;
    w_low_nxt        = r_low_cnt;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_word_cnt_nxt   = r_word_cnt;
    w_shift_nxt      = r_shift;
    w_word_nxt       = r_word;
    w_word_count_nxt = r_word_count;
    w_valid_nxt      = 1'b0;
    w_done_nxt       = 1'b0;
    w_error_nxt      = 1'b0;
    w_bit            = 1'b0;
    if (!i_enable) begin
      // disable wins over every in-flight event, including a gap in this same cycle
      w_state_nxt    = S_IDLE;
      w_high_nxt     = '0;
      w_low_nxt      = '0;
      w_bit_cnt_nxt  = '0;
      w_word_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_high_nxt  = '0;
          w_low_nxt   = '0;
          w_state_nxt = w_line ? S_STUCK : S_LOW;
        end
        S_LOW: begin
          if (w_line) begin
            w_state_nxt = S_HIGH;
            w_high_nxt  = C_ONE;
            w_low_nxt   = '0;
          end else begin
            w_low_nxt = sat_inc(r_low_cnt);
            if (r_low_cnt == C_LAST) begin
              w_error_nxt    = (r_bit_cnt != 5'd0);
              w_done_nxt     = (r_word_cnt != 8'd0);
              w_bit_cnt_nxt  = '0;
              w_word_cnt_nxt = '0;
            end
          end
        end
        S_HIGH: begin
          if (!w_line) begin
            w_state_nxt = S_LOW;
            w_low_nxt   = '0;
            w_high_nxt  = '0;
            w_bit       = (r_high_cnt >= C_THRESHOLD);
            if (r_high_cnt < C_MIN_HIGH) begin
              w_error_nxt = 1'b1;
            end else if (w_decode_en) begin
              w_shift_nxt = {r_shift[21:0], w_bit};
              if (r_bit_cnt == 5'd23) begin
                w_word_nxt       = {r_shift, w_bit};
                w_valid_nxt      = 1'b1;
                w_word_count_nxt = r_word_cnt;
                w_word_cnt_nxt   = (r_word_cnt == 8'hFF) ? r_word_cnt : r_word_cnt + 8'd1;
                w_bit_cnt_nxt    = '0;
              end else begin
                w_bit_cnt_nxt = r_bit_cnt + 5'd1;
              end
            end
          end else if (r_high_cnt == C_LAST) begin
            w_high_nxt    = sat_inc(r_high_cnt);
            w_error_nxt   = 1'b1;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_STUCK;
          end else begin
            w_high_nxt = sat_inc(r_high_cnt);
          end
        end
        S_STUCK: begin
          if (!w_line) begin
            w_state_nxt = S_LOW;
            w_low_nxt   = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_state      <= S_IDLE;
      r_high_cnt   <= '0;
      r_low_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
      r_shift      <= '0;
      r_word       <= '0;
      r_word_count <= '0;
      r_word_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_sync1      <= i_serial_in;
      r_sync2      <= r_sync1;
      r_state      <= w_state_nxt;
      r_high_cnt   <= w_high_nxt;
      r_low_cnt    <= w_low_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_word       <= w_word_nxt;
      r_word_count <= w_word_count_nxt;
      r_word_valid <= w_valid_nxt;
      r_frame_done <= w_done_nxt;
      r_error      <= w_error_nxt;
    end
  end

`ifdef WS2811_DECODER_FORWARD_EN
  logic r_fwd_armed, r_fwd_active, r_serial_out;
  logic w_fwd_stop;

  assign w_decode_en = (r_word_cnt == 8'd0);
  assign w_fwd_stop  = (w_state_nxt == S_IDLE) ||
                       (r_state == S_LOW && !w_line && r_low_cnt == C_LAST);

  // armed once word 0 completes; forwarding starts on the next rising line edge
  always_ff @(posedge i_clock) begin
    if (i_reset || w_fwd_stop) begin
      r_fwd_armed  <= 1'b0;
      r_fwd_active <= 1'b0;
      r_serial_out <= 1'b0;
    end else begin
      if (w_valid_nxt) begin
        r_fwd_armed <= 1'b1;
      end else if (r_fwd_armed && w_line) begin
        r_fwd_armed <= 1'b0;
      end
      if (r_fwd_armed && w_line) begin
        r_fwd_active <= 1'b1;
      end
      r_serial_out <= (r_fwd_active || r_fwd_armed) && w_line;
    end
  end

  assign o_serial_out = r_serial_out;
`else
  assign w_decode_en = 1'b1;
`endif

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_word_count = r_word_count;
  assign o_frame_done = r_frame_done;
  assign o_error      = r_error;
  assign o_db_estado  = r_state;

endmodule

// File: tb/tb_ws2811_serial_decoder.sv
// Bench for ws2811_serial_decoder: pulse-level stimulus scored against an event model of the pin waveform.
module tb_ws2811_serial_decoder;
  localparam int BIT_THRESHOLD = 30;
  localparam int MIN_HIGH      = 5;
  localparam int RESET_CYCLES  = 2500;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        serial_in = 1'b0;
  logic [23:0] word;
  logic        word_valid;
  logic [7:0]  word_count;
  logic        frame_done;
  logic        error;
  logic [1:0]  db_estado;
`ifdef WS2811_DECODER_FORWARD_EN
  logic        serial_out;
`endif

  ws2811_serial_decoder #(
    .BIT_THRESHOLD(BIT_THRESHOLD),
    .MIN_HIGH(MIN_HIGH),
    .RESET_CYCLES(RESET_CYCLES)
  ) dut (
    .i_clock(clock),
    .i_reset(reset),
    .i_enable(enable),
    .i_serial_in(serial_in),
    .o_word(word),
    .o_word_valid(word_valid),
    .o_word_count(word_count),
    .o_frame_done(frame_done),
    .o_error(error),
`ifdef WS2811_DECODER_FORWARD_EN
    .o_serial_out(serial_out),
`endif
    .o_db_estado(db_estado)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // observed events, logged by the monitor
  int          obs_wv_cyc[$];
  logic [23:0] obs_wv_word[$];
  logic [7:0]  obs_wv_cnt[$];
  int          obs_err[$];
  int          obs_done[$];
  // expected events, produced by the model
  int          exp_wv_cyc[$];
  logic [23:0] exp_wv_word[$];
  logic [7:0]  exp_wv_cnt[$];
  int          exp_err[$];
  int          exp_done[$];

  // model: a pin change after edge t shows at the outputs after edge t+3
  int          m_bits = 0;
  logic [23:0] m_shift = '0;
  int          m_wcnt = 0;
  int          m_gap_ref = 0;
  bit          m_gap_pend = 0;
  int          m_rise = 0;
  bit          m_armed = 0;
  bit          m_fwd = 0;
`ifdef WS2811_DECODER_FORWARD_EN
  bit          exp_hist[int];
`endif

  always @(negedge clock) begin
    if (!reset) begin
      if (word_valid) begin
        obs_wv_cyc.push_back(cyc);
        obs_wv_word.push_back(word);
        obs_wv_cnt.push_back(word_count);
      end
      if (error) obs_err.push_back(cyc);
      if (frame_done) obs_done.push_back(cyc);
`ifdef WS2811_DECODER_FORWARD_EN
      exp_hist[cyc] = serial_in & m_fwd;
      if (exp_hist.exists(cyc - 3)) chk("serial_out", serial_out, exp_hist[cyc - 3]);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // a gap fires RESET_CYCLES+3 after its reference unless something at cycle r pre-empts it
  task automatic resolve(input int r);
    int t;
    if (m_gap_pend && (r - m_gap_ref > RESET_CYCLES)) begin
      t = m_gap_ref + RESET_CYCLES + 3;
      if (m_bits != 0) exp_err.push_back(t);
      if (m_wcnt != 0) exp_done.push_back(t);
      m_bits  = 0;
      m_wcnt  = 0;
      m_armed = 0;
      m_fwd   = 0;
    end
    m_gap_pend = 0;
  endtask

  task automatic rise();
    resolve(cyc);
    m_rise = cyc;
    if (m_armed) begin
      m_fwd   = 1;
      m_armed = 0;
    end
    serial_in = 1'b1;
  endtask

  task automatic fall();
    int  h;
    bit  dec;
    h = cyc - m_rise;
    serial_in = 1'b0;
`ifdef WS2811_DECODER_FORWARD_EN
    dec = (m_wcnt == 0);
`else
    dec = 1'b1;
`endif
    if (h >= RESET_CYCLES) begin
      exp_err.push_back(m_rise + RESET_CYCLES + 2);
      m_bits = 0;
    end else if (h < MIN_HIGH) begin
      exp_err.push_back(cyc + 3);
    end else if (dec) begin
      m_shift = {m_shift[22:0], (h >= BIT_THRESHOLD)};
      m_bits++;
      if (m_bits == 24) begin
        exp_wv_cyc.push_back(cyc + 3);
        exp_wv_word.push_back(m_shift);
        exp_wv_cnt.push_back(8'(m_wcnt));
        if (m_wcnt < 255) m_wcnt++;
        m_bits = 0;
`ifdef WS2811_DECODER_FORWARD_EN
        m_armed = 1;
`endif
      end
    end
    m_gap_ref  = cyc;
    m_gap_pend = 1;
  endtask

  task automatic pulse(input int h, input int l);
    rise();
    step(h);
    fall();
    step(l);
  endtask

  // mode 0: nominal 15/47 and 35/27 timing; mode 1: random legal timing
  task automatic send_bits(input logic [23:0] w, input int n, input int mode);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = w[23 - i];
      if (mode == 0) begin
        if (b) pulse(35, 27);
        else   pulse(15, 47);
      end else begin
        if (b) pulse($urandom_range(60, BIT_THRESHOLD), $urandom_range(50, 2));
        else   pulse($urandom_range(BIT_THRESHOLD - 1, MIN_HIGH), $urandom_range(50, 2));
      end
    end
  endtask

  task automatic drop_enable(input int hold);
    enable = 1'b0;
    resolve(cyc - 2);
    m_bits  = 0;
    m_wcnt  = 0;
    m_armed = 0;
    m_fwd   = 0;
    step(1);
    chk("idle_state", db_estado, 2'b00);
    step(hold - 1);
    enable     = 1'b1;
    m_gap_ref  = cyc - 2;
    m_gap_pend = 1;
  endtask

  initial begin
    #(20 * 200000);
    $display("FAIL timeout: run exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] w;
    int bnd[3];
    int n;
    bnd[0] = MIN_HIGH;
    bnd[1] = BIT_THRESHOLD - 1;
    bnd[2] = BIT_THRESHOLD;

    step(5);
    chk("rst_word", word, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_count", word_count, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_error", error, 0);
    chk("rst_state", db_estado, 0);
    reset = 1'b0;
    step(3);
    enable     = 1'b1;
    m_gap_ref  = cyc - 2;
    m_gap_pend = 1;
    step(5);
    chk("low_state", db_estado, 2'b01);

    send_bits(24'hA5C3F0, 24, 0);
    step(2600);

    send_bits(24'h000001, 24, 0);
    send_bits(24'hFFFFFF, 24, 0);
    send_bits(24'h123456, 24, 0);
    step(2600);
    send_bits(24'($urandom), 24, 1);
    step(2600);

    send_bits(24'($urandom), 10, 0);
    step(2600);

    w = 24'($urandom);
    send_bits(w, 10, 0);
    pulse(3, 40);
    send_bits(w << 10, 14, 0);
    step(2600);

    for (int i = 0; i < 24; i++) pulse(bnd[i % 3], 2);
    step(40);
    pulse(MIN_HIGH - 1, 2);
    step(2600);

    repeat (5) send_bits(24'($urandom), 24, 1);
    step(2600);

    rise();
    step(2600);
    chk("stuck_state", db_estado, 2'b11);
    step(400);
    fall();
    step(30);
    send_bits(24'($urandom), 24, 0);
    step(40);

    send_bits(24'($urandom), 12, 0);
    drop_enable(20);
    send_bits(24'($urandom), 24, 0);
    step(2600);

    send_bits(24'h111111, 24, 0);
    send_bits(24'h222222, 24, 0);
    step(2600);

    resolve(cyc - 3);

    chk("n_word_valid", obs_wv_cyc.size(), exp_wv_cyc.size());
    n = (obs_wv_cyc.size() < exp_wv_cyc.size()) ? obs_wv_cyc.size() : exp_wv_cyc.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("wv%0d_cycle", i), obs_wv_cyc[i], exp_wv_cyc[i]);
      chk($sformatf("wv%0d_word", i), obs_wv_word[i], exp_wv_word[i]);
      chk($sformatf("wv%0d_count", i), obs_wv_cnt[i], exp_wv_cnt[i]);
    end
    chk("n_error", obs_err.size(), exp_err.size());
    n = (obs_err.size() < exp_err.size()) ? obs_err.size() : exp_err.size();
    for (int i = 0; i < n; i++) chk($sformatf("err%0d_cycle", i), obs_err[i], exp_err[i]);
    chk("n_frame_done", obs_done.size(), exp_done.size());
    n = (obs_done.size() < exp_done.size()) ? obs_done.size() : exp_done.size();
    for (int i = 0; i < n; i++) chk($sformatf("done%0d_cycle", i), obs_done[i], exp_done[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ws2811_serial_decoder.md
# ws2811_serial_decoder

Receive-side counterpart to the WS2811 array controller. It decodes a WS2811 single-wire NRZ pulse stream into 24-bit GRB words and detects the latch/reset gap. It sits on the loopback or strip-DOUT input pin. It serves self-test of the LED transmit path and pixel emulation on the board.

## Interface
- `BIT_THRESHOLD`, default 30: minimum high-time in clocks for a decoded `1` (0.6 µs at 50 MHz).
- `MIN_HIGH`, default 5: high pulses shorter than this many clocks are glitches.
- `RESET_CYCLES`, default 2500: low-time in clocks that constitutes a reset gap (50 µs). Also the stuck-high limit.
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: decoder runs while high.
- `serial_in` input 1: asynchronous WS2811 data line. Passes through a 2-FF synchronizer internally.
- `word` output 24: last decoded word, MSB received first.
- `word_valid` output 1: one-cycle pulse when `word` updates.
- `word_count` output 8: 0-based index of the word shown with `word_valid`.
- `frame_done` output 1: one-cycle pulse on a reset gap that follows at least one word.
- `error` output 1: one-cycle pulse on glitch, partial word at gap, or stuck-high.
- `serial_out` output 1: forwarded stream. Present only with `WS2811_DECODER_FORWARD_EN`.
- `db_estado` output 2: current state, for debug.

## Operation
- **Reset.** All outputs are 0 (`word` = 0, `db_estado` = 00). All counters are cleared. The synchronizer flops are cleared.
- **Counters.** `high_cnt` and `low_cnt` are `$clog2(RESET_CYCLES+1)` bits wide and saturate. `bit_cnt` is 5 bits. Internal word count is 8 bits and saturates at 255.
- **Line timing.** "line" means the synchronized `serial_in`, which lags the pin by 2 cycles.
- **IDLE (00).**
  - Entered when `enable` = 0. This takes priority from any state on the next edge and silently discards a partial word; no error.
  - When `enable` = 1: go to LOW if line = 0, else to STUCK.
- **LOW (01).** `low_cnt` increments every cycle.
  - Line 1 → HIGH, with `high_cnt` = 1 and `low_cnt` = 0.
  - When `low_cnt` reaches `RESET_CYCLES`, exactly once per gap:
    - if `bit_cnt` ≠ 0, pulse `error`;
    - if word count ≠ 0, pulse `frame_done`;
    - clear `bit_cnt` and word count;
    - remain in LOW.
- **HIGH (10).** `high_cnt` increments.
  - Line 0 with `high_cnt` < `MIN_HIGH`: pulse `error`, drop the bit, go to LOW.
  - Line 0 otherwise: bit = (`high_cnt` ≥ `BIT_THRESHOLD`). Shift it into the word MSB-first, increment `bit_cnt`, go to LOW.
  - On the 24th bit: register `word`, pulse `word_valid` with `word_count` = current index, increment word count, clear `bit_cnt`.
  - `high_cnt` reaching `RESET_CYCLES`: pulse `error`, clear `bit_cnt`, go to STUCK.
- **STUCK (11).** Wait for line 0, then go to LOW with `low_cnt` = 0.
- **Threshold boundaries.** `high_cnt` equal to `BIT_THRESHOLD` decodes as 1. `high_cnt` equal to `MIN_HIGH` is a valid bit.
- **Simultaneous events.** A reset gap and `enable` falling in the same cycle resolve to IDLE, with no pulses.

## Timing
- `word_valid` asserts 3 cycles after the pin falling edge of the 24th bit: 2 cycles of synchronizer plus 1 decode register.
- `frame_done` asserts `RESET_CYCLES` + 3 cycles after the last pin falling edge.
- `word`, `word_count` and `word_valid` update in the same cycle.
- `word` holds its value until the next word completes.
- `error`, `word_valid` and `frame_done` are never high for more than one cycle.
- `enable` deassertion reaches IDLE one cycle later.
- Maximum decodable rate: both the high time and the low time must be ≥ 2 cycles, in addition to the `MIN_HIGH` rule.

## Configuration
- **`WS2811_DECODER_FORWARD_EN` defined:** the block behaves as a pixel.
  - Only word index 0 of each frame is decoded and reported (`word_valid` once per frame).
  - From the next rising line edge after word 0 completes, `serial_out` follows the line through one register. Total pin-to-pin latency is 3 cycles.
  - Forwarding stops at the reset gap, in IDLE, and on `reset`.
  - `serial_out` is 0 whenever it is not forwarding.
- **Not defined:** there is no `serial_out` port, and every word is decoded and reported.

## Test plan
All scenarios use 50 MHz with default parameters. A `0` bit is 15 high / 47 low clocks. A `1` bit is 35 high / 27 low clocks.

- **Single word.** Reset, `enable` = 1, send 0xA5C3F0 → one `word_valid` with `word` = 0xA5C3F0 and `word_count` = 0, 3 cycles after the last fall; `error` never pulses.
- **Frame of three words.** Send 0x000001, 0xFFFFFF, 0x123456, then hold low for 2600 cycles → three `word_valid` with counts 0, 1, 2 → `frame_done` 2503 cycles after the last fall → next word reports count 0.
- **Partial word.** Send 10 bits, then hold low for 2600 cycles → one `error`, no `word_valid`, no `frame_done`.
- **Glitch.** Send 10 bits, a 3-clock high pulse, then 14 bits → one `error`, then `word_valid` carrying the 24 real bits.
- **Stuck and enable handling.**
  - Hold high for 3000 cycles → `error` at `high_cnt` = 2500, `db_estado` = 11.
  - Release and send a word → decodes correctly.
  - Drop `enable` mid-word → `db_estado` = 00 next cycle, no pulses.
- **Forwarding (`WS2811_DECODER_FORWARD_EN`).** Send 0x111111, then 0x222222 → a single `word_valid` (0x111111); `serial_out` reproduces the 0x222222 pulses exactly, delayed 3 cycles; `serial_out` = 0 during the first word.
